// File: rtl/clk_mode_pkg.sv
// Shared constants for the clock-mode selector: level/divide-factor table
// and the FSM state encoding.
package clk_mode_pkg;

  localparam int NUM_LEVELS = 8;
  localparam int LEVEL_W    = 3;
  localparam int MODE_W     = 31;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_e;

  // Divide factor per level; index 0 is the slowest output clock.
  localparam logic [NUM_LEVELS-1:0][MODE_W-1:0] FACTOR_TABLE = {
    31'd250_000,    31'd500_000,    31'd1_000_000,  31'd2_500_000,
    31'd5_000_000,  31'd10_000_000, 31'd25_000_000, 31'd50_000_000
  };

endpackage

// File: rtl/key_debounce.sv
// Raw button -> 2-FF synchronizer -> stability debouncer -> one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [1:0]    vld_pipe;
  logic          stable_q;
  logic          prev_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q   <= '0;
      vld_pipe <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], i_key};
      vld_pipe <= {vld_pipe[0], 1'b1};
      prev_q   <= stable_q;
      // A key must be seen released after reset before it may fire.
      if (vld_pipe[1] && !sync_q[1]) armed_q <= 1'b1;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_press = stable_q & ~prev_q & armed_q;

endmodule

// File: rtl/clk_mode_sel.sv
// Button-driven divide-factor selector with manual stepping and a ping-pong
// auto-sweep across the eight levels.
module clk_mode_sel
  import clk_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SWEEP_CYCLES    = 50_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_up,
  input  logic              i_key_down,
  input  logic              i_key_auto,
  output logic [MODE_W-1:0] o_clk_mode,
  output logic [LEVEL_W-1:0] o_level,
  output logic              o_sweep,
  output logic              o_changed
);

  localparam int NUM_KEYS = 3;
  localparam int TW       = $clog2(SWEEP_CYCLES + 1);

  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] press;

  assign keys = {i_key_auto, i_key_down, i_key_up};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key   (keys[k]),
      .o_press (press[k])
    );
  end

  logic up_p, dn_p, tg_p;
  assign up_p = press[0];
  assign dn_p = press[1];
  assign tg_p = press[2];

  state_e            state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [MODE_W-1:0] mode_q;
  logic              chg_q;
  logic              tc;

  assign tc = (tmr_q == TW'(SWEEP_CYCLES - 1));

  // Auto pulse takes priority over key steps and over the sweep terminal count.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tmr_d   = '0;
    case (state_q)
      MANUAL: begin
        if (tg_p)
          state_d = (level_q == LEVEL_MAX) ? SWEEP_DOWN : SWEEP_UP;
        else if (up_p && !dn_p && level_q != LEVEL_MAX)
          level_d = level_q + 1'b1;
        else if (dn_p && !up_p && level_q != '0)
          level_d = level_q - 1'b1;
      end
      SWEEP_UP: begin
        if (tg_p) begin
          state_d = MANUAL;
        end else begin
          tmr_d = tc ? '0 : tmr_q + 1'b1;
          if (tc) begin
            if (level_q != LEVEL_MAX) level_d = level_q + 1'b1;
            if (level_q >= LEVEL_MAX - 1'b1) state_d = SWEEP_DOWN;
          end
        end
      end
      SWEEP_DOWN: begin
        if (tg_p) begin
          state_d = MANUAL;
        end else begin
          tmr_d = tc ? '0 : tmr_q + 1'b1;
          if (tc) begin
            if (level_q != '0) level_d = level_q - 1'b1;
            if (level_q <= LEVEL_W'(1)) state_d = SWEEP_UP;
          end
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= MANUAL;
      level_q <= '0;
      tmr_q   <= '0;
      mode_q  <= FACTOR_TABLE[0];
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      tmr_q   <= tmr_d;
      mode_q  <= FACTOR_TABLE[level_q];
      chg_q   <= (FACTOR_TABLE[level_q] != mode_q);
    end
  end

  assign o_clk_mode = mode_q;
  assign o_level    = level_q;
  assign o_sweep    = (state_q != MANUAL);
  assign o_changed  = chg_q;

endmodule

// File: tb/tb_clk_mode_sel.sv
// Directed bench for clk_mode_sel with short debounce/sweep periods.
module tb_clk_mode_sel;

  localparam int D = 4;
  localparam int S = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        ku = 1'b0, kd = 1'b0, ka = 1'b0;
  logic [30:0] o_clk_mode;
  logic [2:0]  o_level;
  logic        o_sweep;
  logic        o_changed;

  int n_tests = 0;
  int n_fail  = 0;
  int chg_cnt = 0;

  logic [30:0] exp_mode [8];

  clk_mode_sel #(.DEBOUNCE_CYCLES(D), .SWEEP_CYCLES(S)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_key_up   (ku),
    .i_key_down (kd),
    .i_key_auto (ka),
    .o_clk_mode (o_clk_mode),
    .o_level    (o_level),
    .o_sweep    (o_sweep),
    .o_changed  (o_changed)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      if (o_changed) chg_cnt++;
    end
  endtask

  task automatic press(input int k, input int hold, input int rel);
    if (k == 0) ku = 1'b1;
    else if (k == 1) kd = 1'b1;
    else ka = 1'b1;
    tick(hold);
    ku = 1'b0; kd = 1'b0; ka = 1'b0;
    tick(rel);
  endtask

  task automatic test_reset;
    i_rst = 1'b0;
    tick(3);
    n_tests++;
    if ({o_level, o_clk_mode, o_sweep, o_changed} !== {3'd0, 31'd50_000_000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: got lvl=%0d mode=%0d sw=%b chg=%b want 0/50000000/0/0",
               o_level, o_clk_mode, o_sweep, o_changed);
    end
    i_rst = 1'b1;
    chg_cnt = 0;
    tick(10);
    n_tests++;
    if (o_level !== 3'd0 || o_clk_mode !== 31'd50_000_000 || chg_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_release: got lvl=%0d mode=%0d pulses=%0d want 0/50000000/0",
               o_level, o_clk_mode, chg_cnt);
    end
  endtask

  task automatic test_single_press;
    chg_cnt = 0;
    ku = 1'b1;
    tick(6);
    n_tests++;
    if (o_level !== 3'd0) begin
      n_fail++; $display("FAIL press_early: got lvl=%0d want 0", o_level);
    end
    tick(1);
    n_tests++;
    if (o_level !== 3'd1 || o_clk_mode !== 31'd50_000_000) begin
      n_fail++; $display("FAIL press_lvl_at7: got lvl=%0d mode=%0d want 1/50000000", o_level, o_clk_mode);
    end
    tick(1);
    n_tests++;
    if (o_clk_mode !== 31'd25_000_000 || o_changed !== 1'b1) begin
      n_fail++; $display("FAIL press_mode_at8: got mode=%0d chg=%b want 25000000/1", o_clk_mode, o_changed);
    end
    tick(1);
    n_tests++;
    if (o_changed !== 1'b0) begin
      n_fail++; $display("FAIL press_chg_1cyc: got chg=%b want 0", o_changed);
    end
    tick(11);
    ku = 1'b0;
    tick(20);
    n_tests++;
    if (o_level !== 3'd1 || chg_cnt != 1) begin
      n_fail++; $display("FAIL press_total: got lvl=%0d pulses=%0d want 1/1", o_level, chg_cnt);
    end
  endtask

  task automatic test_bounce;
    chg_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      ku = 1'b1; tick(2);
      ku = 1'b0; tick(2);
    end
    press(0, 15, 15);
    n_tests++;
    if (o_level !== 3'd2 || chg_cnt != 1) begin
      n_fail++; $display("FAIL bounce: got lvl=%0d pulses=%0d want 2/1", o_level, chg_cnt);
    end
  endtask

  task automatic test_saturate_up;
    for (int lv = 3; lv <= 7; lv++) begin
      press(0, 20, 20);
      n_tests++;
      if (o_level !== 3'(lv) || o_clk_mode !== exp_mode[lv]) begin
        n_fail++;
        $display("FAIL up_step: got lvl=%0d mode=%0d want %0d/%0d", o_level, o_clk_mode, lv, exp_mode[lv]);
      end
    end
    chg_cnt = 0;
    press(0, 20, 20);
    n_tests++;
    if (o_level !== 3'd7 || o_clk_mode !== 31'd250_000 || chg_cnt != 0) begin
      n_fail++;
      $display("FAIL up_saturate: got lvl=%0d mode=%0d pulses=%0d want 7/250000/0", o_level, o_clk_mode, chg_cnt);
    end
  endtask

  task automatic test_down;
    press(1, 20, 20);
    n_tests++;
    if (o_level !== 3'd6 || o_clk_mode !== 31'd500_000) begin
      n_fail++; $display("FAIL down_step: got lvl=%0d mode=%0d want 6/500000", o_level, o_clk_mode);
    end
  endtask

  task automatic test_sweep;
    ka = 1'b1;
    tick(7);
    n_tests++;
    if (o_sweep !== 1'b1 || o_level !== 3'd6) begin
      n_fail++; $display("FAIL sweep_enter: got sw=%b lvl=%0d want 1/6", o_sweep, o_level);
    end
    tick(1);
    ka = 1'b0;
    tick(6);
    n_tests++;
    if (o_level !== 3'd6) begin
      n_fail++; $display("FAIL sweep_before_step: got lvl=%0d want 6", o_level);
    end
    tick(1);
    n_tests++;
    if (o_level !== 3'd7 || o_sweep !== 1'b1) begin
      n_fail++; $display("FAIL sweep_step_up: got lvl=%0d sw=%b want 7/1", o_level, o_sweep);
    end
    tick(8);
    n_tests++;
    if (o_level !== 3'd6 || o_sweep !== 1'b1) begin
      n_fail++; $display("FAIL sweep_step_down: got lvl=%0d sw=%b want 6/1", o_level, o_sweep);
    end
    ka = 1'b1;
    tick(7);
    n_tests++;
    if (o_sweep !== 1'b0 || o_level !== 3'd6) begin
      n_fail++; $display("FAIL sweep_exit: got sw=%b lvl=%0d want 0/6", o_sweep, o_level);
    end
    tick(1);
    ka = 1'b0;
    tick(20);
    n_tests++;
    if (o_level !== 3'd6 || o_sweep !== 1'b0) begin
      n_fail++; $display("FAIL manual_hold: got lvl=%0d sw=%b want 6/0", o_level, o_sweep);
    end
    press(0, 20, 20);
    n_tests++;
    if (o_level !== 3'd7) begin
      n_fail++; $display("FAIL manual_up_after_sweep: got lvl=%0d want 7", o_level);
    end
    press(1, 20, 20);
    n_tests++;
    if (o_level !== 3'd6) begin
      n_fail++; $display("FAIL manual_down_after_sweep: got lvl=%0d want 6", o_level);
    end
  endtask

  task automatic test_auto_vs_tc;
    press(2, 8, 8);
    ka = 1'b1;
    tick(6);
    n_tests++;
    if (o_level !== 3'd7 || o_sweep !== 1'b1) begin
      n_fail++; $display("FAIL tc_pre: got lvl=%0d sw=%b want 7/1", o_level, o_sweep);
    end
    tick(1);
    n_tests++;
    if (o_level !== 3'd7 || o_sweep !== 1'b0) begin
      n_fail++; $display("FAIL auto_beats_tc: got lvl=%0d sw=%b want 7/0", o_level, o_sweep);
    end
    tick(1);
    ka = 1'b0;
    tick(20);
    n_tests++;
    if (o_level !== 3'd7 || o_clk_mode !== 31'd250_000) begin
      n_fail++; $display("FAIL tc_after: got lvl=%0d mode=%0d want 7/250000", o_level, o_clk_mode);
    end
  endtask

  task automatic test_enter_at_top;
    ka = 1'b1;
    tick(7);
    n_tests++;
    if (o_sweep !== 1'b1 || o_level !== 3'd7) begin
      n_fail++; $display("FAIL top_enter: got sw=%b lvl=%0d want 1/7", o_sweep, o_level);
    end
    tick(1);
    ka = 1'b0;
    tick(7);
    n_tests++;
    if (o_level !== 3'd6) begin
      n_fail++; $display("FAIL top_goes_down: got lvl=%0d want 6", o_level);
    end
    press(2, 7, 20);
    n_tests++;
    if (o_sweep !== 1'b0 || o_level !== 3'd6) begin
      n_fail++; $display("FAIL top_exit: got sw=%b lvl=%0d want 0/6", o_sweep, o_level);
    end
  endtask

  task automatic test_reset_mid_debounce;
    ku = 1'b1;
    tick(2);
    i_rst = 1'b0;
    tick(1);
    n_tests++;
    if ({o_level, o_clk_mode, o_sweep, o_changed} !== {3'd0, 31'd50_000_000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_vals: got lvl=%0d mode=%0d sw=%b chg=%b want 0/50000000/0/0",
               o_level, o_clk_mode, o_sweep, o_changed);
    end
    tick(2);
    i_rst = 1'b1;
    chg_cnt = 0;
    tick(20);
    n_tests++;
    if (o_level !== 3'd0 || chg_cnt != 0) begin
      n_fail++; $display("FAIL held_through_reset: got lvl=%0d pulses=%0d want 0/0", o_level, chg_cnt);
    end
    ku = 1'b0;
    tick(20);
    ku = 1'b1;
    tick(7);
    n_tests++;
    if (o_level !== 3'd1) begin
      n_fail++; $display("FAIL repress_after_reset: got lvl=%0d want 1", o_level);
    end
    ku = 1'b0;
    tick(20);
  endtask

  initial begin
    exp_mode[0] = 31'd50_000_000; exp_mode[1] = 31'd25_000_000;
    exp_mode[2] = 31'd10_000_000; exp_mode[3] = 31'd5_000_000;
    exp_mode[4] = 31'd2_500_000;  exp_mode[5] = 31'd1_000_000;
    exp_mode[6] = 31'd500_000;    exp_mode[7] = 31'd250_000;
    #1;
    test_reset;
    test_single_press;
    test_bounce;
    test_saturate_up;
    test_down;
    test_sweep;
    test_auto_vs_tc;
    test_enter_at_top;
    test_reset_mid_debounce;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
